// File: rtl/instruction_fetch_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : instruction_fetch_if
// Desc     : Instruction-memory request/response channel between fetch and imem.
// Revision : 1.0
//------------------------------------------------------------------------------
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : instruction_fetch
// Desc     : RISC-V IF stage: PC, in-order imem request tracking, fetch queue
//            and IF/ID register. Optional macro: IF_MISALIGN_CHECK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH     = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    instruction_fetch_if.master imem,
    input  wire logic           id_stall,
    input  wire logic           pc_src,
    input  wire logic [31:0]    new_pc,
    output logic [31:0]         instr,
    output logic [31:0]         pc,
    output logic                instr_valid,
    output logic                misalign
);
    localparam int unsigned c_QAW = $clog2(QUEUE_DEPTH);
    localparam int unsigned c_RAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned c_OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef logic [c_OW-1:0]  out_cnt_t;
    typedef logic [c_RAW-1:0] rq_ptr_t;
    typedef logic [c_QAW-1:0] q_ptr_t;
    typedef logic [c_QAW:0]   q_cnt_t;

    logic [31:0] r_fetch_pc;
    out_cnt_t    r_outstanding;
    out_cnt_t    r_drop_cnt;
    logic [31:0] r_rq_pc [MAX_OUTSTANDING];
    rq_ptr_t     r_rq_wr;
    rq_ptr_t     r_rq_rd;
    logic [31:0] r_q_pc    [QUEUE_DEPTH];
    logic [31:0] r_q_instr [QUEUE_DEPTH];
    q_ptr_t      r_q_wr;
    q_ptr_t      r_q_rd;
    q_cnt_t      r_q_cnt;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;

    logic        w_misalign;
    logic [31:0] w_target;
    logic [31:0] w_credit;
    logic        w_req_valid;
    logic        w_fire;
    logic        w_resp;
    logic        w_dropping;
    logic        w_keep;
    logic        w_redirect;
    logic        w_load;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;
    logic [31:0] w_resp_pc;

    function automatic rq_ptr_t rq_next(input rq_ptr_t p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : rq_ptr_t'(p + 1'b1);
    endfunction

`ifdef IF_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_misalign_set;

    assign w_misalign_set = pc_src && !id_stall && (new_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_misalign_set) begin
            r_misalign <= 1'b1;
        end
    end

    assign w_misalign = r_misalign;
`else
    logic w_unused_low_bits;
    assign w_unused_low_bits = |new_pc[1:0];
    assign w_misalign        = 1'b0;
`endif

    assign w_target    = {new_pc[31:2], 2'b00};
    // Words already promised to the queue: live in-flight requests plus occupancy
    assign w_credit    = 32'(r_outstanding) - 32'(r_drop_cnt) + 32'(r_q_cnt);
    assign w_req_valid = !rst && !w_misalign
                         && (32'(r_outstanding) < MAX_OUTSTANDING)
                         && (w_credit < QUEUE_DEPTH);
    assign w_fire      = w_req_valid && imem.imem_req_ready;
    assign w_resp      = imem.imem_resp_valid;
    assign w_dropping  = w_resp && (r_drop_cnt != '0);
    assign w_keep      = w_resp && !w_dropping && !w_misalign;
    assign w_redirect  = pc_src && !id_stall;
    assign w_load      = !id_stall && !pc_src;
    assign w_pop       = w_load && (r_q_cnt != '0);
    assign w_bypass    = w_load && w_keep && (r_q_cnt == '0);
    assign w_push      = w_keep && !w_bypass && !w_redirect;
    assign w_resp_pc   = r_rq_pc[r_rq_rd];

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_rq_wr       <= '0;
            r_rq_rd       <= '0;
            r_q_wr        <= '0;
            r_q_rd        <= '0;
            r_q_cnt       <= '0;
        end else begin
            r_outstanding <= r_outstanding + out_cnt_t'(w_fire) - out_cnt_t'(w_resp);
            // Everything still owed by memory after this edge belongs to the old path
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_drop_cnt <= r_outstanding + out_cnt_t'(w_fire) - out_cnt_t'(w_resp);
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_dropping) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
            end
            if (w_fire) begin
                r_rq_wr <= rq_next(r_rq_wr);
            end
            if (w_resp) begin
                r_rq_rd <= rq_next(r_rq_rd);
            end
            if (w_redirect) begin
                r_q_wr  <= '0;
                r_q_rd  <= '0;
                r_q_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_q_wr <= r_q_wr + 1'b1;
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + 1'b1;
                end
                r_q_cnt <= r_q_cnt + q_cnt_t'(w_push) - q_cnt_t'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_rq_pc[r_rq_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_pc[r_q_wr]    <= w_resp_pc;
            r_q_instr[r_q_wr] <= imem.imem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= c_NOP;
            r_pc    <= 32'h0000_0000;
            r_valid <= 1'b0;
        end else if (w_pop) begin
            r_instr <= r_q_instr[r_q_rd];
            r_pc    <= r_q_pc[r_q_rd];
            r_valid <= 1'b1;
        end else if (w_bypass) begin
            r_instr <= imem.imem_resp_data;
            r_pc    <= w_resp_pc;
            r_valid <= 1'b1;
        end else if (!id_stall) begin
            r_instr <= c_NOP;
            r_valid <= 1'b0;
        end
    end

    assign instr       = r_instr;
    assign pc          = r_pc;
    assign instr_valid = r_valid;
    assign misalign    = w_misalign;

endmodule
`default_nettype wire
